// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encodings, per-mode Nk/Nr,
// the engine state enum and the GF(2^8) doubling used by the round constant.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128  = 2'd0,
    KEY_192  = 2'd1,
    KEY_256  = 2'd2,
    KEY_RSVD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COPY   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DRAIN  = 2'd3
  } ks_state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      KEY_128: return 4'd4;
      KEY_192: return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (len)
      KEY_128: return 4'd10;
      KEY_192: return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  // Total schedule words 4*(Nr+1)
  function automatic logic [5:0] words_of(input logic [1:0] len);
    case (len)
      KEY_128: return 6'd44;
      KEY_192: return 6'd52;
      default: return 6'd60;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four AES S-boxes applied bytewise to one 32-bit word.
// Each S-box is the GF(2^8) inverse (x^254) followed by the affine map.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    inv  = gf_mul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key schedule: one schedule word per cycle through a
// shared SubWord, grouped into 128-bit round keys on a valid/ready stream.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  input  logic         abort,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         rk_last,
  output logic         err,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; rk_data/rk_index/rk_last hold steady while rk_valid && !rk_ready.

  ks_state_e      r_state, w_next_state;
  logic [255:0]   r_key;
  logic [1:0]     r_mode;
  logic [5:0]     r_i;
  logic [2:0]     r_mod;
  logic [7:0]     r_rcon;
  logic [31:0]    r_win [8];
  logic [31:0]    r_asm [3];
  logic           r_rk_valid;
  logic [127:0]   r_rk_data;
  logic [3:0]     r_rk_index;
  logic           r_rk_last;
  logic           r_err;

  logic [3:0]     w_nk, w_nr;
  logic [2:0]     w_nk_m1;
  logic [5:0]     w_words;
  logic           w_len_ok, w_load, w_reject, w_active;
  logic           w_group_end, w_stall, w_step, w_rcon_more;
  logic [31:0]    w_key_words [8];
  logic [31:0]    w_t, w_sub_in, w_sub_out, w_tx, w_word;

  assign w_nk    = nk_of(r_mode);
  assign w_nr    = nr_of(r_mode);
  assign w_words = words_of(r_mode);
  assign w_nk_m1 = 3'(w_nk - 4'd1);

  always_comb begin
    w_len_ok = 1'b0;
    case (key_len)
      KEY_128: w_len_ok = (MAX_KEY_BITS >= 128);
      KEY_192: w_len_ok = (MAX_KEY_BITS >= 192);
      KEY_256: w_len_ok = (MAX_KEY_BITS >= 256);
      default: w_len_ok = 1'b0;
    endcase
  end

  assign w_load      = (r_state == ST_IDLE) && key_valid && !abort && w_len_ok;
  assign w_reject    = (r_state == ST_IDLE) && key_valid && !abort && !w_len_ok;
  assign w_group_end = (r_i[1:0] == 2'b11);
  // Only the word that would overwrite an unaccepted round key has to wait
  assign w_stall     = w_group_end && r_rk_valid && !rk_ready;
  assign w_step      = w_active && !w_stall && !abort;
  assign w_rcon_more = ({1'b0, r_i} + {3'b000, w_nk}) < {1'b0, w_words};

  always_comb begin
    for (int k = 0; k < 8; k++) w_key_words[k] = r_key[255 - 32*k -: 32];
  end

  assign w_t      = r_win[0];
  assign w_sub_in = (r_mod == 3'd0) ? {w_t[23:0], w_t[31:24]} : w_t;

  aes_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_tx   = w_t;
    w_word = w_key_words[r_i[2:0]];
    if (r_state == ST_EXPAND) begin
      if (r_mod == 3'd0)
        w_tx = w_sub_out ^ {r_rcon, 24'h0};
      else if (r_mode == KEY_256 && r_mod == 3'd4)
        w_tx = w_sub_out;
      w_word = r_win[w_nk_m1] ^ w_tx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_load) w_next_state = ST_COPY;
        ST_COPY:   if (w_step && r_i[2:0] == w_nk_m1) w_next_state = ST_EXPAND;
        ST_EXPAND: if (w_step && r_i == w_words - 6'd1) w_next_state = ST_DRAIN;
        ST_DRAIN:  if (r_rk_valid && rk_ready) w_next_state = ST_IDLE;
        default:   w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    key_ready = (r_state == ST_IDLE);
    w_active  = (r_state == ST_COPY) || (r_state == ST_EXPAND);
    dbg_state = r_state;
  end

  // Window entry 0 is the newest word, so window[i-Nk] sits at entry Nk-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key      <= '0;
      r_mode     <= '0;
      r_i        <= '0;
      r_mod      <= '0;
      r_rcon     <= RCON_INIT;
      r_win      <= '{default: '0};
      r_asm      <= '{default: '0};
      r_rk_valid <= 1'b0;
      r_rk_data  <= '0;
      r_rk_index <= '0;
      r_rk_last  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (abort) begin
        r_i        <= '0;
        r_mod      <= '0;
        r_rcon     <= RCON_INIT;
        r_rk_valid <= 1'b0;
      end else begin
        if (w_load) begin
          r_key  <= key;
          r_mode <= key_len;
          r_i    <= '0;
          r_mod  <= '0;
          r_rcon <= RCON_INIT;
        end
        if (r_rk_valid && rk_ready) r_rk_valid <= 1'b0;
        if (w_step) begin
          r_win[0] <= w_word;
          for (int k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
          r_i   <= r_i + 6'd1;
          r_mod <= (r_mod == w_nk_m1) ? 3'd0 : r_mod + 3'd1;
          if (r_state == ST_EXPAND && r_mod == 3'd0 && w_rcon_more)
            r_rcon <= xtime(r_rcon);
          if (w_group_end) begin
            r_rk_data  <= {r_asm[0], r_asm[1], r_asm[2], w_word};
            r_rk_index <= r_i[5:2];
            r_rk_last  <= (r_i[5:2] == w_nr);
            r_rk_valid <= 1'b1;
          end else begin
            r_asm[r_i[1:0]] <= w_word;
          end
        end
      end
    end
  end

  assign rk_valid = r_rk_valid;
  assign rk_data  = r_rk_data;
  assign rk_index = r_rk_index;
  assign rk_last  = r_rk_last;
  assign err      = r_err;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: FIPS-197 key vectors, backpressure, rejected
// lengths, abort and asynchronous reset, checked through an expected queue.
module tb_aes_key_schedule;

  localparam int EXP_W = 261;  // {mask[128], data[128], index[4], last}
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] RK14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic [127:0] aes128_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         key_valid = 1'b0, abort = 1'b0, rk_ready = 1'b1;
  logic [1:0]   key_len = '0;
  logic [255:0] key = '0;
  logic         key_ready, rk_valid, rk_last, err;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic [1:0]   dbg_state;

  logic         d2_key_valid = 1'b0;
  logic [1:0]   d2_key_len = '0;
  logic         d2_key_ready, d2_rk_valid, d2_rk_last, d2_err;
  logic [127:0] d2_rk_data;
  logic [3:0]   d2_rk_index;
  logic [1:0]   d2_dbg_state;

  aes_key_schedule #(.MAX_KEY_BITS(256)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_len(key_len), .key(key), .abort(abort), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_data(rk_data), .rk_index(rk_index),
    .rk_last(rk_last), .err(err), .dbg_state(dbg_state));

  aes_key_schedule #(.MAX_KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .key_valid(d2_key_valid), .key_ready(d2_key_ready),
    .key_len(d2_key_len), .key(key), .abort(1'b0), .rk_valid(d2_rk_valid),
    .rk_ready(1'b1), .rk_data(d2_rk_data), .rk_index(d2_rk_index),
    .rk_last(d2_rk_last), .err(d2_err), .dbg_state(d2_dbg_state));

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  bit rdy_rand = 1'b0;
  bit t_chk = 1'b0;
  bit b2b_chk = 1'b0;
  int load_edge = 0;
  int last_acc_edge = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    rk_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // driver tasks
  task automatic push_expect(input logic [1:0] len, input logic [255:0] k);
    int nr;
    logic [127:0] m, d;
    nr = (len == 2'd0) ? 10 : (len == 2'd1) ? 12 : 14;
    for (int i = 0; i <= nr; i++) begin
      m = '0;
      d = '0;
      if (len == 2'd0) begin
        m = '1; d = aes128_rk[i];
      end else if (i == 0) begin
        m = '1; d = k[255:128];
      end else if (i == 1) begin
        m = (len == 2'd2) ? '1 : {{64{1'b1}}, 64'h0};
        d = k[127:0];
      end else if (i == nr) begin
        m = '1; d = (len == 2'd1) ? RK12_192 : RK14_256;
      end
      exp_q.push_back({m, d, 4'(i), (i == nr)});
    end
  endtask

  task automatic load_key(input logic [1:0] len, input logic [255:0] k);
    int n;
    key_len = len;
    key = k;
    key_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!key_ready && n < 2000);
    if (!key_ready) begin
      checks++; errors++;
      $display("FAIL load_timeout: key_ready=%0b after %0d cycles, required 1", key_ready, n);
      exp_q.delete();
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || rk_valid) && n < budget);
    if (exp_q.size() != 0 || rk_valid) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d round keys outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic reject_chk(input bit use128, input logic [1:0] len, input string tag);
    if (use128) begin d2_key_len = len; d2_key_valid = 1'b1; end
    else begin key_len = len; key_valid = 1'b1; end
    @(posedge clk); #1;
    d2_key_valid = 1'b0;
    key_valid = 1'b0;
    check($sformatf("%s_err_pulse", tag), 128'(use128 ? d2_err : err), 128'd1);
    check($sformatf("%s_key_ready", tag), 128'(use128 ? d2_key_ready : key_ready), 128'd1);
    @(posedge clk); #1;
    check($sformatf("%s_err_clear", tag), 128'(use128 ? d2_err : err), 128'd0);
    repeat (4) @(posedge clk);
    #1;
    check($sformatf("%s_no_rk", tag), 128'(use128 ? d2_rk_valid : rk_valid), 128'd0);
    check($sformatf("%s_idle", tag), 128'(use128 ? d2_dbg_state : dbg_state), 128'd0);
  endtask

  // scoreboard monitor
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic [3:0]   prev_idx;
  logic         prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 128'(rk_valid), 128'd1);
        check("hold_data", rk_data, prev_data);
        check("hold_index", 128'(rk_index), 128'(prev_idx));
        check("hold_last", 128'(rk_last), 128'(prev_last));
      end
      if (key_valid && key_ready && !abort) begin
        load_edge = cyc + 1;
        if (b2b_chk) begin
          check("b2b_load_edge", 128'(load_edge), 128'(last_acc_edge + 1));
          b2b_chk = 1'b0;
        end
      end
      if (rk_valid && rk_ready && !abort) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rk: got index %0d, required no round key", rk_index);
        end else begin
          logic [EXP_W-1:0] e;
          e = exp_q.pop_front();
          if (e[260:133] != '0)
            check($sformatf("rk_data[%0d]", e[4:1]), rk_data & e[260:133], e[132:5] & e[260:133]);
          check("rk_index", 128'(rk_index), 128'(e[4:1]));
          check($sformatf("rk_last[%0d]", e[4:1]), 128'(rk_last), 128'(e[0]));
          if (t_chk)
            check($sformatf("rk_time[%0d]", e[4:1]), 128'(cyc), 128'(load_edge + 4 + 4*int'(e[4:1])));
        end
        if (rk_last) last_acc_edge = cyc + 1;
      end
      prev_stall = rk_valid && !rk_ready && !abort;
      prev_data  = rk_data;
      prev_idx   = rk_index;
      prev_last  = rk_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_key_ready", 128'(key_ready), 128'd1);
    check("rst_rk_valid", 128'(rk_valid), 128'd0);
    check("rst_rk_data", rk_data, 128'd0);
    check("rst_rk_index", 128'(rk_index), 128'd0);
    check("rst_rk_last", 128'(rk_last), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // full-rate runs with latency checks, AES-192 loaded back-to-back
    t_chk = 1'b1;
    push_expect(2'd0, K128);
    load_key(2'd0, K128);
    b2b_chk = 1'b1;
    push_expect(2'd1, K192);
    load_key(2'd1, K192);
    wait_done(400);
    push_expect(2'd2, K256);
    load_key(2'd2, K256);
    wait_done(400);

    // 30% consumer duty cycle
    t_chk = 1'b0;
    rdy_rand = 1'b1;
    push_expect(2'd0, K128); load_key(2'd0, K128); wait_done(2000);
    push_expect(2'd1, K192); load_key(2'd1, K192); wait_done(2000);
    push_expect(2'd2, K256); load_key(2'd2, K256); wait_done(2000);
    rdy_rand = 1'b0;
    @(posedge clk); #1;

    reject_chk(1'b0, 2'd3, "rsvd_len");
    reject_chk(1'b1, 2'd2, "len256_max128");
    reject_chk(1'b1, 2'd3, "rsvd_len_max128");

    // abort once round key 5 is presented
    t_chk = 1'b1;
    push_expect(2'd0, K128);
    load_key(2'd0, K128);
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!(rk_valid && rk_index == 4'd5) && n < 200);
    end
    check("abort_at_index", 128'(rk_index), 128'd5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_rk_valid", 128'(rk_valid), 128'd0);
    check("abort_key_ready", 128'(key_ready), 128'd1);
    check("abort_pending", 128'(exp_q.size()), 128'd6);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;

    // asynchronous reset in the middle of an AES-256 expansion
    push_expect(2'd2, K256);
    load_key(2'd2, K256);
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_state", 128'(dbg_state), 128'd2);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_rk_valid", 128'(rk_valid), 128'd0);
    check("arst_key_ready", 128'(key_ready), 128'd1);
    check("arst_rk_data", rk_data, 128'd0);
    check("arst_rk_index", 128'(rk_index), 128'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    push_expect(2'd0, K128);
    load_key(2'd0, K128);
    wait_done(400);

    check("final_queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES key-schedule engine for AES-128, AES-192 and AES-256, selected per key at run time. It accepts a cipher key over a valid/ready handshake and streams the Nr+1 128-bit round keys in order over a second valid/ready handshake, with full backpressure. It generates one 32-bit schedule word per cycle through a single shared SubWord. It sits between the key register file and the round datapath and replaces the fixed-width combinational AES-256 expansion step.

## Interface
- MAX_KEY_BITS, 256, largest key length the instance accepts (128, 192 or 256); a longer requested length is rejected
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- key_valid  input  1  key/key_len presented
- key_ready  output  1  engine idle, load accepted when key_valid && key_ready
- key_len  input  2  0=128, 1=192, 2=256, 3=reserved
- key  input  256  cipher key, w0 = key[255:224]; AES-128 uses key[255:128], AES-192 uses key[255:64]
- abort  input  1  synchronous flush to IDLE
- rk_valid  output  1  round key available
- rk_ready  input  1  consumer accepts when rk_valid && rk_ready
- rk_data  output  128  round key, first word in [127:96]
- rk_index  output  4  round number 0..Nr of rk_data
- rk_last  output  1  rk_data is round Nr
- err  output  1  one-cycle pulse on rejected load

## Operation
- Nk/Nr: 4/10, 6/12, 8/14. Total words W = 4*(Nr+1) = 44/52/60.
- States: IDLE, COPY (word counter i < Nk), EXPAND (i < W), DRAIN (last key held, awaiting accept).
- IDLE: key_ready=1. On load, latch key, mode, i=0, rcon=0x01, and go to COPY. Rejected loads (key_len=3 or length > MAX_KEY_BITS) stay in IDLE and pulse err.
- COPY: word i = key word i, pushed into the Nk-deep window (8 entries, Nk used).
- EXPAND: t = window[i-1]. If i%Nk==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}, then rcon = xtime(rcon). Else if Nk==8 and i%8==4: t = SubWord(t). Word i = window[i-Nk] ^ t.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36. It is never advanced beyond what the mode needs.
- Word assembler collects 4 words. When the 4th word of a group is produced, it loads rk_data and rk_index, sets rk_valid, and sets rk_last when the index equals Nr.
- Stall: word generation halts (i, window and rcon frozen) only when the 4th word of a group is due while rk_valid && !rk_ready. A same-cycle accept and reload is permitted with no bubble.
- After word W-1, go to DRAIN. On the last accept, go to IDLE with rk_valid=0.
- key_valid while not IDLE is ignored; key_ready=0.
- abort (any state) forces IDLE next cycle: rk_valid=0, counters cleared, pending key discarded. abort wins over a simultaneous load.

## Timing
- Reset values: key_ready=1, rk_valid=0, rk_data=0, rk_index=0, rk_last=0, err=0. State is IDLE, rcon=0x01.
- Load accepted at edge E0. Round key 0 is valid after edge E0+4. Without backpressure, round key k is valid after edge E0+4+4k. Round key Nr appears 4*(Nr+1) cycles after the load.
- key_ready returns to 1 in the cycle after the last rk accept. A back-to-back load is accepted on that cycle.
- rk_data, rk_index and rk_last are stable while rk_valid && !rk_ready.
- err is asserted in the cycle after the rejecting edge, for exactly one cycle.
- Reset asserted mid-operation clears everything asynchronously. No output glitches to X.

## Structure
- Shared package aes_pkg: key_len encodings, Nk/Nr per mode, state enum, and xtime function.
- Sub-module: the existing SubWord (4 S-boxes), instantiated once. No other hierarchy.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk0 = key, rk1 = a0fafe1788542cb123a339392a6c7605, rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1, 11 beats 4 cycles apart.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 beats, rk12 = e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 15 beats, rk14 = fe4890d1e6188d0b046df344706c631e.
- Random rk_ready (30% duty) on all three vectors -> identical key sequence, outputs stable while stalled, no lost or duplicated index.
- key_len=3 (and key_len=2 with MAX_KEY_BITS=128) -> err single pulse, key_ready stays 1, no rk_valid.
- abort at rk_index=5 and rst_n low mid-EXPAND -> rk_valid=0 next cycle / immediately, and a fresh AES-128 load afterwards produces correct rk10.
